// File: rtl/cv_cart_fetch.sv
// Cartridge fetch unit: turns Z80 cartridge reads into external memory requests,
// holds the CPU in WAIT until data returns, and keeps a one-entry last-address cache.
module cv_cart_fetch #(
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 63
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [15:0]       a_i,
  input  logic [5:0]        cart_page_i,
  input  logic              cart_en_80_n_i,
  input  logic              cart_en_a0_n_i,
  input  logic              cart_en_c0_n_i,
  input  logic              cart_en_e0_n_i,
  input  logic              cart_en_sg1000_n_i,
  input  logic              rd_n_i,
  input  logic              cache_inv_i,
  output logic              wait_n_o,
  output logic [7:0]        d_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_data_i,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TERM = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              sel, sel_d, start, en_slot, hit;
  logic [19:0]       addr20;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        cnt, cnt_nxt;
  logic              cache_valid, cache_valid_nxt;
  logic [ADDR_W-1:0] cache_tag, cache_tag_nxt;
  logic [7:0]        cache_data, cache_data_nxt;
  logic              wait_n_nxt, mem_req_nxt, timeout_nxt;
  logic [7:0]        d_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;

  assign en_slot = ~(cart_en_80_n_i & cart_en_a0_n_i & cart_en_c0_n_i & cart_en_e0_n_i);
  assign sel     = ~rd_n_i & (en_slot | ~cart_en_sg1000_n_i);
  assign start   = sel & ~sel_d;

  // ColecoVision slots are banked by the decoder page; SG-1000 space maps flat.
  always_comb begin
    addr20 = 20'h00000;
    if (en_slot) begin
      addr20 = {cart_page_i, a_i[13:0]};
    end else begin
      addr20 = {4'h0, a_i};
    end
  end

  generate
    if (ADDR_W > 20) begin : g_ext
      assign addr = {{(ADDR_W-20){1'b0}}, addr20};
    end else if (ADDR_W == 20) begin : g_eq
      assign addr = addr20;
    end else begin : g_trunc
      assign addr = addr20[ADDR_W-1:0];
    end
  endgenerate

  assign hit = cache_valid & (cache_tag == addr);

  // Next-state and next-output logic; the hit uses the cache valid before any invalidate.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    wait_n_nxt     = wait_n_o;
    mem_req_nxt    = mem_req_o;
    mem_addr_nxt   = mem_addr_o;
    d_nxt          = d_o;
    timeout_nxt    = 1'b0;
    cache_tag_nxt  = cache_tag;
    cache_data_nxt = cache_data;
    cache_valid_nxt = cache_valid;
    case (state)
      IDLE: begin
        if (start && hit) begin
          d_nxt     = cache_data;
          state_nxt = DONE;
        end else if (start) begin
          mem_addr_nxt = addr;
          mem_req_nxt  = 1'b1;
          wait_n_nxt   = 1'b0;
          cnt_nxt      = 8'd0;
          state_nxt    = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        cnt_nxt = cnt + 8'd1;
        if (mem_ack_i) begin
          d_nxt           = mem_data_i;
          cache_tag_nxt   = mem_addr_o;
          cache_data_nxt  = mem_data_i;
          cache_valid_nxt = 1'b1;
          mem_req_nxt     = 1'b0;
          wait_n_nxt      = 1'b1;
          state_nxt       = DONE;
        end else if (cnt == TERM) begin
          d_nxt       = 8'hFF;
          mem_req_nxt = 1'b0;
          wait_n_nxt  = 1'b1;
          timeout_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          state_nxt = REQ;
        end
      end
      DONE: begin
        wait_n_nxt = 1'b1;
        if (!sel) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        wait_n_nxt  = 1'b1;
        mem_req_nxt = 1'b0;
      end
    endcase
    if (cache_inv_i) begin
      cache_valid_nxt = 1'b0;
    end else begin
      cache_valid_nxt = cache_valid_nxt;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      sel_d       <= 1'b0;
      cnt         <= 8'd0;
      wait_n_o    <= 1'b1;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      d_o         <= 8'hFF;
      timeout_o   <= 1'b0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= 8'h00;
    end else begin
      state       <= state_nxt;
      sel_d       <= sel;
      cnt         <= cnt_nxt;
      wait_n_o    <= wait_n_nxt;
      mem_req_o   <= mem_req_nxt;
      mem_addr_o  <= mem_addr_nxt;
      d_o         <= d_nxt;
      timeout_o   <= timeout_nxt;
      cache_valid <= cache_valid_nxt;
      cache_tag   <= cache_tag_nxt;
      cache_data  <= cache_data_nxt;
    end
  end

endmodule

// File: tb/tb_cv_cart_fetch.sv
// Directed bench for cv_cart_fetch: miss/hit, SG-1000 mapping, timeout, terminal-cycle
// ack, invalidate-vs-fill and reset in the middle of a request.
module tb_cv_cart_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] a;
  logic [5:0]  cart_page;
  logic        en_80_n, en_a0_n, en_c0_n, en_e0_n, en_sg_n;
  logic        rd_n, cache_inv, mem_ack;
  logic [7:0]  mem_data;
  logic        wait_n, mem_req, timeout;
  logic [7:0]  d;
  logic [19:0] mem_addr;

  int tests = 0;
  int fails = 0;
  int low_cnt, req_cnt, to_cnt;

  always #5 clk = ~clk;

  cv_cart_fetch #(.ADDR_W(20), .TIMEOUT(63)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .a_i(a), .cart_page_i(cart_page),
    .cart_en_80_n_i(en_80_n), .cart_en_a0_n_i(en_a0_n), .cart_en_c0_n_i(en_c0_n),
    .cart_en_e0_n_i(en_e0_n), .cart_en_sg1000_n_i(en_sg_n), .rd_n_i(rd_n),
    .cache_inv_i(cache_inv), .wait_n_o(wait_n), .d_o(d), .mem_req_o(mem_req),
    .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data), .timeout_o(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deselect();
    rd_n = 1'b1;
    en_80_n = 1'b1; en_a0_n = 1'b1; en_c0_n = 1'b1; en_e0_n = 1'b1; en_sg_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; a = 16'h0000; cart_page = 6'h00; cache_inv = 1'b0;
    mem_ack = 1'b0; mem_data = 8'h00;
    deselect();
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_wait", 32'(wait_n), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'h00000);
    chk("rst_d", 32'(d), 32'hFF);
    chk("rst_to", 32'(timeout), 32'd0);

    // Miss at C123 page 5: {6'h05, 14'h0123} = 20'h14123.
    cart_page = 6'h05; a = 16'hC123; en_c0_n = 1'b0; rd_n = 1'b0;
    tick();
    chk("miss_req", 32'(mem_req), 32'd1);
    chk("miss_addr", 32'(mem_addr), 32'h14123);
    low_cnt = (wait_n == 1'b0) ? 1 : 0;
    repeat (3) begin
      tick();
      if (!wait_n) low_cnt++;
    end
    mem_ack = 1'b1; mem_data = 8'hA5;
    tick();
    mem_ack = 1'b0;
    if (!wait_n) low_cnt++;
    chk("miss_wait_low", 32'(low_cnt), 32'd4);
    chk("miss_d", 32'(d), 32'hA5);
    chk("miss_req_drop", 32'(mem_req), 32'd0);
    deselect(); tick();
    rd_n = 1'b0; en_c0_n = 1'b0;
    tick();
    chk("hit_req", 32'(mem_req), 32'd0);
    chk("hit_wait", 32'(wait_n), 32'd1);
    chk("hit_d", 32'(d), 32'hA5);
    deselect(); tick();

    // SG-1000 flat mapping ignores the page.
    a = 16'h1234; en_sg_n = 1'b0; rd_n = 1'b0;
    tick();
    chk("sg_req", 32'(mem_req), 32'd1);
    chk("sg_addr", 32'(mem_addr), 32'h01234);
    mem_ack = 1'b1; mem_data = 8'h5A;
    tick();
    mem_ack = 1'b0;
    chk("sg_d", 32'(d), 32'h5A);
    deselect(); tick();

    // Timeout at C200 page 5 -> 20'h14200.
    a = 16'hC200; en_c0_n = 1'b0; rd_n = 1'b0;
    tick();
    req_cnt = (mem_req == 1'b1) ? 1 : 0;
    to_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (mem_req) req_cnt++;
      if (timeout) to_cnt++;
    end
    chk("to_req_cycles", 32'(req_cnt), 32'd63);
    chk("to_pulses", 32'(to_cnt), 32'd1);
    chk("to_d", 32'(d), 32'hFF);
    chk("to_wait", 32'(wait_n), 32'd1);
    deselect(); tick();
    rd_n = 1'b0; en_c0_n = 1'b0;
    tick();
    chk("to_reissue", 32'(mem_req), 32'd1);

    // Ack exactly on the terminal-count cycle of this re-issued request.
    repeat (62) tick();
    chk("term_still_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_data = 8'h3C;
    tick();
    mem_ack = 1'b0;
    chk("term_d", 32'(d), 32'h3C);
    chk("term_to", 32'(timeout), 32'd0);
    chk("term_req", 32'(mem_req), 32'd0);
    deselect(); tick();
    rd_n = 1'b0; en_c0_n = 1'b0;
    tick();
    chk("term_cached", 32'(mem_req), 32'd0);
    deselect(); tick();

    // Invalidate coinciding with fill at E000 page 1 -> 20'h06000.
    cart_page = 6'h01; a = 16'hE000; en_e0_n = 1'b0; rd_n = 1'b0;
    tick();
    chk("inv_addr", 32'(mem_addr), 32'h06000);
    tick();
    mem_ack = 1'b1; mem_data = 8'h77; cache_inv = 1'b1;
    tick();
    mem_ack = 1'b0; cache_inv = 1'b0;
    chk("inv_d", 32'(d), 32'h77);
    deselect(); tick();
    rd_n = 1'b0; en_e0_n = 1'b0;
    tick();
    chk("inv_miss", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_data = 8'h78;
    tick();
    mem_ack = 1'b0;
    deselect(); tick();

    // Reset during REQ at 8005 page 2 -> 20'h08005, then a stray ack.
    cart_page = 6'h02; a = 16'h8005; en_80_n = 1'b0; rd_n = 1'b0;
    tick();
    chk("rreq_req", 32'(mem_req), 32'd1);
    chk("rreq_addr", 32'(mem_addr), 32'h08005);
    reset_n = 1'b0; deselect();
    tick();
    reset_n = 1'b1;
    chk("rreq_wait", 32'(wait_n), 32'd1);
    chk("rreq_req0", 32'(mem_req), 32'd0);
    chk("rreq_d", 32'(d), 32'hFF);
    mem_ack = 1'b1; mem_data = 8'h99;
    tick();
    mem_ack = 1'b0;
    chk("stray_req", 32'(mem_req), 32'd0);
    chk("stray_d", 32'(d), 32'hFF);
    rd_n = 1'b0; en_80_n = 1'b0;
    tick();
    chk("stray_nofill", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_data = 8'h11;
    tick();
    mem_ack = 1'b0;
    deselect(); tick();

    // Write cycle: enable active with rd_n high.
    en_80_n = 1'b0; a = 16'h9000;
    tick(); tick();
    chk("wr_req", 32'(mem_req), 32'd0);
    chk("wr_wait", 32'(wait_n), 32'd1);
    deselect(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
